// File: rtl/pingpong_data_buf_if.sv
// Handshake bundle for the ping-pong data buffer: write side, read side and mux outputs.
// The flush line exists only when PPBUF_FLUSH_EN is defined.
interface pingpong_data_buf_if #(
  parameter int DATA_BITS = 16
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [DATA_BITS-1:0] wr_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [DATA_BITS-1:0] bank0_data;
  logic [DATA_BITS-1:0] bank1_data;
  logic                 bank_sel;
`ifdef PPBUF_FLUSH_EN
  logic                 flush;
`endif

  // Producer/consumer side.
  modport master (
    output wr_valid, wr_data, rd_ready,
`ifdef PPBUF_FLUSH_EN
    output flush,
`endif
    input  wr_ready, rd_valid, bank0_data, bank1_data, bank_sel
  );

  // Buffer side.
  modport slave (
    input  wr_valid, wr_data, rd_ready,
`ifdef PPBUF_FLUSH_EN
    input  flush,
`endif
    output wr_ready, rd_valid, bank0_data, bank1_data, bank_sel
  );
endinterface

// File: rtl/pingpong_data_buf.sv
// Two-bank ping-pong buffer: one bank fills while the other drains into the output mux.
// Optional early bank close via flush when PPBUF_FLUSH_EN is defined.
module pingpong_data_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  pingpong_data_buf_if.slave    bus,
  output logic [3:0]            dbg_bank_state
);
  localparam int DATA_BITS = 16;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  bank_state_e          state_q [2];
  bank_state_e          state_d [2];
  logic [DATA_BITS-1:0] mem [2][DEPTH];
  logic                 wr_bank;
  logic                 rd_bank;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [1:0]           full;
  logic                 wr_fire;
  logic                 rd_fire;
  logic                 wr_close;
  logic                 rd_last;
  logic [AW-1:0]        rd_last_idx;
  logic [AW:0]          wr_count;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // ready and valid depend only on registered state, never on the other side's input.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      full[b] = (state_q[b] == FULL) || (state_q[b] == DRAINING);
    end
  end

  assign bus.wr_ready = !full[wr_bank];
  assign bus.rd_valid = full[rd_bank];
  assign bus.bank_sel = rd_bank;
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign rd_fire      = bus.rd_valid && bus.rd_ready;
  assign wr_count     = {1'b0, wr_ptr} + {{AW{1'b0}}, wr_fire};

`ifdef PPBUF_FLUSH_EN
  logic [AW:0] len [2];

  // A flush counts a write landing in the same cycle; an empty bank ignores it.
  assign wr_close    = (wr_fire && (wr_ptr == AW'(DEPTH - 1))) ||
                       (bus.flush && (wr_count != '0));
  assign rd_last_idx = AW'(len[rd_bank] - 1'b1);
`else
  assign wr_close    = wr_fire && (wr_ptr == AW'(DEPTH - 1));
  assign rd_last_idx = AW'(DEPTH - 1);
`endif

  assign rd_last = rd_fire && (rd_ptr == rd_last_idx);

  // The inactive bank parks its output on word 0.
  assign bus.bank0_data = mem[0][rd_bank ? {AW{1'b0}} : rd_ptr];
  assign bus.bank1_data = mem[1][rd_bank ? rd_ptr : {AW{1'b0}}];

  assign dbg_bank_state = {state_q[1], state_q[0]};

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      if (wr_bank == b[0]) begin
        if (wr_close) begin
          state_d[b] = FULL;
        end else if (wr_fire && state_q[b] == EMPTY) begin
          state_d[b] = FILLING;
        end
      end
      if (rd_bank == b[0]) begin
        if (rd_last) begin
          state_d[b] = EMPTY;
        end else if (rd_fire && state_q[b] == FULL) begin
          state_d[b] = DRAINING;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[b][i] <= '0;
        end
      end
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
`ifdef PPBUF_FLUSH_EN
      len[0]  <= '0;
      len[1]  <= '0;
`endif
    end else begin
      if (wr_fire) begin
        mem[wr_bank][wr_ptr] <= bus.wr_data;
      end
      if (wr_close) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
`ifdef PPBUF_FLUSH_EN
        len[wr_bank] <= wr_count;
`endif
      end else if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_last) begin
        rd_ptr  <= '0;
        rd_bank <= ~rd_bank;
      end else if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: doc/pingpong_data_buf.md
# pingpong_data_buf

Two-bank ping-pong data buffer in the CNN datapath, directly upstream of the 16-bit 2-to-1 output multiplexer. The write side fills one bank while the read side drains the other. Each bank presents its current read word on its own output, and `bank_sel` tells the mux which bank is active. Both sides use valid/ready handshakes, so a producer (e.g. the input-feature fetch) and a consumer (the PE array) can run decoupled.

## Interface
- `DEPTH`, default 8: words per bank. Must be a power of two, ≥2.
- `AW`, default $clog2(DEPTH): pointer width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  write word offered.
- `wr_ready`  out  1  write bank can accept.
- `wr_data`  in  `DATA_BITS`  write word (`DATA_BITS` = 16, from def.v).
- `rd_valid`  out  1  read bank holds an unread word.
- `rd_ready`  in  1  consumer takes the current word.
- `bank0_data`  out  `DATA_BITS`  word at the read pointer of bank 0 (mux input 1).
- `bank1_data`  out  `DATA_BITS`  word at the read pointer of bank 1 (mux input 2).
- `bank_sel`  out  1  current read bank (mux select).
- `flush`  in  1  present only with `PPBUF_FLUSH_EN`.

## Operation
- State: `mem[2][DEPTH]`, `full[1:0]`, `len[1:0]` (with flush only), `wr_bank`, `rd_bank`, `wr_ptr`, `rd_ptr`.
- Per-bank states are EMPTY, FILLING, FULL and DRAINING:
  - EMPTY→FILLING on the first write.
  - FILLING→FULL on the last write.
  - FULL→DRAINING on the first read.
  - DRAINING→EMPTY on the last read.
- `wr_ready = !full[wr_bank]`. A write fires when `wr_valid && wr_ready`:
  - `mem[wr_bank][wr_ptr] <= wr_data`, then `wr_ptr++`.
  - At `wr_ptr == DEPTH-1`: set `full[wr_bank]`, clear `wr_ptr` to 0, toggle `wr_bank`.
- `rd_valid = full[rd_bank]`. A read fires when `rd_valid && rd_ready`:
  - `rd_ptr++`.
  - At `rd_ptr == last` (DEPTH-1, or `len[rd_bank]-1` with flush): clear `full[rd_bank]`, clear `rd_ptr` to 0, toggle `rd_bank`.
- `bank_sel = rd_bank`.
- `bank0_data = mem[0][bank_sel ? 0 : rd_ptr]`, and `bank1_data = mem[1][bank_sel ? rd_ptr : 0]`. The inactive bank always shows its word 0.
- Write and read always target different banks, so the same bank is never set and cleared in one cycle. Simultaneous write and read both complete.
- Both banks FULL: `wr_ready=0`, the producer stalls.
- Both banks EMPTY: `rd_valid=0`, and the data outputs are don't-care but stable.
- Pointers wrap only at bank completion, never mid-bank.
- `rst` mid-operation discards all contents and ends any partial bank.

## Timing
- Reset values:
  - `wr_ready=1`, `rd_valid=0`, `bank_sel=0`.
  - All `mem` words 0, so `bank0_data = bank1_data = 0`.
  - Pointers, banks, `full` and `len` all 0.
- Write-to-read latency: the completing write at edge N sets `full`. `rd_valid` goes high in the cycle after N, with word 0 already on the selected output.
- Read outputs are combinational from registers. The new word appears in the cycle after each accepted read.
- Bank release: after the last read at edge M, `wr_ready` for that bank is high in cycle M+1.
- Sustained throughput is one word/cycle per side once primed.

## Configuration
- `PPBUF_FLUSH_EN` defined:
  - Adds the `flush` input and the `len` registers.
  - When `flush` is high and `wr_ptr != 0` (counting a write in the same cycle), the current write bank closes early: `full` is set, `len` = words written, `wr_ptr` clears to 0, `wr_bank` toggles.
  - The read side drains only `len` words.
  - `flush` with an empty write bank is a no-op.
  - On a normal (non-flush) completion, `len` = DEPTH.
- `PPBUF_FLUSH_EN` undefined: no `flush` port and no `len` registers. Banks always hold exactly DEPTH words.

## Test plan
- Reset: assert `rst` for 2 cycles mid-fill → `wr_ready=1`, `rd_valid=0`, `bank_sel=0`, both data outputs 0, and a fresh fill restarts at word 0.
- Single bank, DEPTH=8: write 0x0001..0x0008 with `rd_ready=0` → `rd_valid` rises the cycle after the 8th write; `bank_sel=0`; `bank0_data=0x0001`.
- Full drain: `rd_ready=1` → `bank0_data` steps 0x0001..0x0008; after the 8th read, `rd_valid=0` and `bank_sel=1`.
- Backpressure: write 16 words with `rd_ready=0` → `wr_ready=0` after the 16th write; a 17th `wr_valid` is not accepted; one read does not reopen the bank; 8 reads do.
- Concurrent streaming: continuous `wr_valid`/`rd_ready` with an incrementing pattern for 64 words → output sequence identical to input, `bank_sel` toggling every 8 reads, no bubbles after priming.
- `PPBUF_FLUSH_EN`: write 3 words (0xA0..0xA2), pulse `flush` → `rd_valid=1`; exactly 3 words are read; then the bank swaps and the next bank's fill starts at pointer 0.
